// File: rtl/mix_layer_engine_pkg.sv
// Shared constants, state codes and small helpers for the mix layer engine.
package mix_layer_engine_pkg;

    localparam int HID_DIM   = 24;
    localparam int N_LEN     = 16;
    localparam int F_LEN     = 8;
    localparam int STATE_LEN = 4;

    // Top-level state codes that select a mix layer.
    localparam logic [STATE_LEN-1:0] ST_IDLE = 4'd0;
    localparam logic [STATE_LEN-1:0] ST_MIX1 = 4'd1;
    localparam logic [STATE_LEN-1:0] ST_MIX2 = 4'd2;
    localparam logic [STATE_LEN-1:0] ST_MIX3 = 4'd3;

    // Layer index carried in the upper bits of the weight address.
    localparam int LAYER_W = 2;
    typedef enum logic [LAYER_W-1:0] {
        LAYER_1 = 2'd0,
        LAYER_2 = 2'd1,
        LAYER_3 = 2'd2
    } layer_t;

    // Weight address {layer, row}; row HID_DIM is the bias row.
    localparam int W_ADDR_W = LAYER_W + $clog2(HID_DIM + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } fsm_t;

    function automatic logic is_mix(input logic [STATE_LEN-1:0] s);
        return (s == ST_MIX1) || (s == ST_MIX2) || (s == ST_MIX3);
    endfunction

    function automatic layer_t layer_of(input logic [STATE_LEN-1:0] s);
        layer_t l;
        case (s)
            ST_MIX2: l = LAYER_2;
            ST_MIX3: l = LAYER_3;
            default: l = LAYER_1;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/mix_layer_engine_mac_lane.sv
// One output column: signed MAC into a wide accumulator, bias add,
// shift back to the element format, saturate and optional ReLU.
module mix_mac_lane #(
    parameter int N_LEN = 16,
    parameter int F_LEN = 8,
    parameter int ACC_W = 37
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    is_bias,
    input  logic                    relu,
    input  logic signed [N_LEN-1:0] x,
    input  logic signed [N_LEN-1:0] w,
    output logic        [N_LEN-1:0] y
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (N_LEN - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (N_LEN - 1)));
    localparam logic        [N_LEN-1:0] RES_MAX = {1'b0, {(N_LEN-1){1'b1}}};
    localparam logic        [N_LEN-1:0] RES_MIN = {1'b1, {(N_LEN-1){1'b0}}};

    logic signed [2*N_LEN-1:0] prod;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   shifted;
    logic        [N_LEN-1:0]   res;

    // Product, bias-completed row value and its narrowed, clamped result.
    always_comb begin
        prod     = (2*N_LEN)'(x) * (2*N_LEN)'(w);
        prod_ext = ACC_W'(prod);
        bias_ext = ACC_W'(w) <<< F_LEN;
        sum      = acc + bias_ext;
        shifted  = sum >>> F_LEN;
        if (shifted > SAT_MAX)
            res = RES_MAX;
        else if (shifted < SAT_MIN)
            res = RES_MIN;
        else
            res = shifted[N_LEN-1:0];
        y = (relu && res[N_LEN-1]) ? '0 : res;
    end

    // Accumulate products; the bias cycle finishes the row and clears for the next.
    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (en) begin
            if (is_bias)
                acc <= '0;
            else
                acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/mix_layer_engine.sv
// Time-multiplexed Y = act(X*W_L + b_L): one row of HID_DIM MAC lanes,
// weights streamed row by row from a synchronous external memory.
module mix_layer_engine
    import mix_layer_engine_pkg::*;
#(
    parameter int HID_DIM   = mix_layer_engine_pkg::HID_DIM,
    parameter int N_LEN     = mix_layer_engine_pkg::N_LEN,
    parameter int F_LEN     = mix_layer_engine_pkg::F_LEN,
    parameter int STATE_LEN = mix_layer_engine_pkg::STATE_LEN
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [STATE_LEN-1:0]                  state,
    input  logic                                  valid_in,
    input  logic [HID_DIM*HID_DIM*N_LEN-1:0]      d,
    output logic [LAYER_W+$clog2(HID_DIM+1)-1:0]  w_addr,
    input  logic [HID_DIM*N_LEN-1:0]              w_data,
    output logic                                  busy,
    output logic                                  drop,
    output logic                                  valid_out,
    output logic [HID_DIM*HID_DIM*N_LEN-1:0]      q
);

    localparam int K_W   = $clog2(HID_DIM + 1);
    localparam int ROW_W = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;
    localparam int ACC_W = 2 * N_LEN + K_W;

    fsm_t   fsm_q, fsm_nxt;
    logic   accept;
    layer_t layer_q;
    logic   relu;

    // Address-side counters (what is on w_addr) and their data-side copies.
    logic [ROW_W-1:0] i_q, i_nxt, dat_i;
    logic [K_W-1:0]   k_q, k_nxt, dat_k;
    logic             dat_vld;
    logic             last_addr;
    logic             dat_bias;

    logic [HID_DIM-1:0][HID_DIM-1:0][N_LEN-1:0] xbuf;
    logic [HID_DIM-1:0][HID_DIM-1:0][N_LEN-1:0] outbuf;
    logic [HID_DIM-1:0][N_LEN-1:0]              row_y;
    logic [N_LEN-1:0]                           x_sel;

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst)
            fsm_q <= S_IDLE;
        else
            fsm_q <= fsm_nxt;
    end

    // Next state, acceptance and drop; anything arriving outside IDLE is dropped.
    always_comb begin
        fsm_nxt = fsm_q;
        accept  = 1'b0;
        drop    = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (valid_in) begin
                    if (is_mix(state)) begin
                        accept  = 1'b1;
                        fsm_nxt = S_RUN;
                    end else
                        drop = 1'b1;
                end
            end
            S_RUN: begin
                drop = valid_in;
                if (last_addr)
                    fsm_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                drop    = valid_in;
                fsm_nxt = S_DONE;
            end
            default: begin
                drop    = valid_in;
                fsm_nxt = S_IDLE;
            end
        endcase
        if (rst) begin
            accept = 1'b0;
            drop   = 1'b0;
        end
    end

    // Address walk order and operand selection for the row being accumulated.
    always_comb begin
        last_addr = (i_q == ROW_W'(HID_DIM - 1)) && (k_q == K_W'(HID_DIM));
        if (k_q == K_W'(HID_DIM)) begin
            k_nxt = '0;
            i_nxt = i_q + ROW_W'(1);
        end else begin
            k_nxt = k_q + K_W'(1);
            i_nxt = i_q;
        end
        dat_bias = (dat_k == K_W'(HID_DIM));
        x_sel    = dat_bias ? '0 : xbuf[dat_i][dat_k[ROW_W-1:0]];
        relu     = (layer_q != LAYER_3);
    end

    // Operand latch, address issue, row write-back and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            layer_q   <= LAYER_1;
            xbuf      <= '0;
            outbuf    <= '0;
            q         <= '0;
            w_addr    <= '0;
            i_q       <= '0;
            k_q       <= '0;
            dat_i     <= '0;
            dat_k     <= '0;
            dat_vld   <= 1'b0;
            busy      <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            dat_vld   <= (fsm_q == S_RUN);
            dat_i     <= i_q;
            dat_k     <= k_q;
            if (accept) begin
                xbuf    <= d;
                layer_q <= layer_of(state);
                i_q     <= '0;
                k_q     <= '0;
                w_addr  <= {layer_of(state), K_W'(0)};
                busy    <= 1'b1;
            end
            if (fsm_q == S_RUN && !last_addr) begin
                i_q    <= i_nxt;
                k_q    <= k_nxt;
                w_addr <= {layer_q, k_nxt};
            end
            if (dat_vld && dat_bias)
                outbuf[dat_i] <= row_y;
            if (fsm_q == S_DONE) begin
                q         <= outbuf;
                valid_out <= 1'b1;
                busy      <= 1'b0;
            end
        end
    end

    for (genvar j = 0; j < HID_DIM; j++) begin : g_lane
        mix_mac_lane #(
            .N_LEN (N_LEN),
            .F_LEN (F_LEN),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .en      (dat_vld),
            .is_bias (dat_bias),
            .relu    (relu),
            .x       (x_sel),
            .w       (w_data[j*N_LEN +: N_LEN]),
            .y       (row_y[j])
        );
    end

endmodule
